// File: rtl/arb_rr_mux4_if.sv
// Request/data bundle between four bit sources and the round-robin mux arbiter.
interface arb_rr_mux4_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       dout;
  logic       dout_vld;

  modport master (
    output req, din,
    input  gnt, sel, busy, dout, dout_vld
  );

  modport slave (
    input  req, din,
    output gnt, sel, busy, dout, dout_vld
  );
endinterface

// File: rtl/arb_rr_mux4.sv
// Four-source round-robin arbiter driving a registered 4:1 single-bit mux.
// Optional hold timeout compiled in with ARB_HOLD_TIMEOUT_EN.
module arb_rr_mux4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input logic         clk,
  input logic         rst,
  arb_rr_mux4_if.slave bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t     state_r, state_s;
  logic [1:0] ptr_r, ptr_s;
  logic [3:0] hold_cnt_r, hold_cnt_s;
  logic [3:0] gnt_r, gnt_s;
  logic [1:0] sel_r, sel_s;
  logic       busy_r, busy_s;
  logic       dout_r, dout_vld_r;
  logic       owner_keeps_s, force_rot_s;
  logic [3:0] cand_s;
  logic [1:0] win_s;

  // First set bit of cand, scanning start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] cand, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && cand[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

  // Candidate selection, next-state and next-grant logic.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    hold_cnt_s = hold_cnt_r;
    gnt_s      = gnt_r;
    sel_s      = sel_r;
    busy_s     = busy_r;

    owner_keeps_s = (state_r == GRANT) && bus.req[sel_r];
`ifdef ARB_HOLD_TIMEOUT_EN
    // The owner is excluded from the search only when someone else is waiting.
    force_rot_s = owner_keeps_s && (hold_cnt_r == 4'(HOLD_MAX - 1))
                  && ((bus.req & ~gnt_r) != 4'b0000);
    cand_s      = force_rot_s ? (bus.req & ~gnt_r) : bus.req;
`else
    force_rot_s = 1'b0;
    cand_s      = bus.req;
`endif
    win_s = rr_pick(cand_s, ptr_r);

    case (state_r)
      IDLE, GRANT: begin
        if (owner_keeps_s && !force_rot_s) begin
          hold_cnt_s = (hold_cnt_r == 4'd15) ? 4'd15 : hold_cnt_r + 4'd1;
        end else if (cand_s != 4'b0000) begin
          state_s    = GRANT;
          gnt_s      = 4'b0001 << win_s;
          sel_s      = win_s;
          busy_s     = 1'b1;
          ptr_s      = win_s + 2'd1;
          hold_cnt_s = 4'd0;
        end else begin
          state_s    = IDLE;
          gnt_s      = 4'b0000;
          busy_s     = 1'b0;
          hold_cnt_s = 4'd0;
        end
      end
      default: begin
        state_s    = IDLE;
        gnt_s      = 4'b0000;
        busy_s     = 1'b0;
        hold_cnt_s = 4'd0;
      end
    endcase
  end

  // Arbiter state, pointer and registered grant outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= 2'd0;
      hold_cnt_r <= 4'd0;
      gnt_r      <= 4'b0000;
      sel_r      <= 2'd0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      hold_cnt_r <= hold_cnt_s;
      gnt_r      <= gnt_s;
      sel_r      <= sel_s;
      busy_r     <= busy_s;
    end
  end

  // Registered mux output, one cycle behind the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r     <= 1'b0;
      dout_vld_r <= 1'b0;
    end else begin
      dout_r     <= busy_r ? bus.din[sel_r] : 1'b0;
      dout_vld_r <= busy_r;
    end
  end

  assign bus.gnt      = gnt_r;
  assign bus.sel      = sel_r;
  assign bus.busy     = busy_r;
  assign bus.dout     = dout_r;
  assign bus.dout_vld = dout_vld_r;

endmodule
